mem_access_wb: RTL
==================

Name: mem_access_wb

Overview:
- Consumer end of the EX/MEM pipeline register. Takes the registered EX/MEM outputs and performs the data-memory access over a req/ack handshake.
- Produces the MEM/WB pipeline register outputs.
- Asserts a stall back to the earlier stages while an access is outstanding.
- Sits between the EX/MEM register and write-back. Replaces a zero-latency data memory with a variable-latency one.

Parameters:
- DATA_W, 32, width of data path and addresses
- REG_W, 5, register-index width
- TIMEOUT, 16, maximum cycles to wait for dmem_ack before aborting the access
- POISON, 32'hDEADBEEF, read data returned when an access times out

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- alu_result  in  DATA_W  from EX/MEM; memory address or ALU result
- read_data2  in  DATA_W  from EX/MEM; store data
- regdst  in  REG_W  from EX/MEM; destination register
- regwrite  in  1  from EX/MEM
- memwrite  in  1  from EX/MEM
- memread  in  1  from EX/MEM
- memtoreg  in  1  from EX/MEM
- dmem_req  out  1  access request, held until ack
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  DATA_W  registered access address
- dmem_wdata  out  DATA_W  registered store data
- dmem_rdata  in  DATA_W  load data, valid with dmem_ack
- dmem_ack  in  1  one-cycle access completion
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- mem_error  out  1  sticky timeout flag
- read_data_out  out  DATA_W  MEM/WB load data
- alu_result_out  out  DATA_W  MEM/WB ALU result
- regdst_out  out  REG_W  MEM/WB destination register
- regwrite_out  out  1  MEM/WB control
- memtoreg_out  out  1  MEM/WB control

Behaviour:
Reset:
- Asserting reset at any time forces state IDLE.
- All registered outputs go to 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_error, and all *_out.
- A reset during ACCESS drops dmem_req immediately. An ack arriving later is ignored.

FSM states: IDLE, ACCESS.
- IDLE, no memory op (memread=0 and memwrite=0):
  - stall=0.
  - At the next edge the MEM/WB outputs load from the inputs; read_data_out loads 0.
  - Latency is 1 cycle.
- IDLE with memread or memwrite:
  - stall=1, combinational.
  - At the edge: capture dmem_addr=alu_result, dmem_wdata=read_data2, dmem_we=memwrite.
  - Capture regdst, regwrite and memtoreg internally.
  - Set dmem_req=1 and go to ACCESS.
  - The MEM/WB outputs take a bubble: regwrite_out=0, memtoreg_out=0, other fields unchanged.
- ACCESS:
  - stall = !dmem_ack; dmem_req stays 1.
  - Each non-ack cycle inserts a bubble into MEM/WB.
  - On dmem_ack, at the edge:
    - read_data_out = dmem_rdata, or 0 for a write.
    - The captured controls go to MEM/WB; alu_result_out = captured address.
    - dmem_req drops to 0 and the state returns to IDLE.
  - stall is low in the ack cycle, so EX/MEM advances at that same edge.
- Timeout:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - If it reaches TIMEOUT-1 without ack, the access completes as if acked, with read_data_out=POISON.
  - mem_error sets and stays set until reset.
  - If dmem_ack arrives in the same cycle as the timeout, the ack wins: normal data is returned and mem_error is unchanged.
- memread and memwrite both 1: treated as a write. read_data_out=0; regwrite passes through unchanged.
- dmem_ack while in IDLE is ignored.
- Minimum memory-op latency is 2 cycles: one IDLE cycle plus one ACCESS cycle with immediate ack.
- Every consumed instruction reaches MEM/WB exactly once; no instruction is dropped or duplicated.

Decomposition:
- Shared pipeline package holds:
  - state encoding (IDLE=1'b0, ACCESS=1'b1)
  - POISON default
  - the MEM/WB field-width constants, shared with the WB stage
- One sub-module, mem_timeout_ctr: a clear/enable saturating counter of width clog2(TIMEOUT) with an expired output.

Test Plan:
- ALU op: alu_result=32'h0000_0010, regdst=5'd3, regwrite=1, no mem op -> next edge alu_result_out=32'h10, regdst_out=3, regwrite_out=1, stall never high.
- Load, ack after 3 ACCESS cycles with dmem_rdata=32'hCAFE_F00D:
  - dmem_addr=alu_result; stall high for 4 cycles.
  - 4 bubbles with regwrite_out=0, then read_data_out=32'hCAFEF00D, memtoreg_out=1, regwrite_out=1.
- Store, addr 32'h40, read_data2=32'h1234, immediate ack -> dmem_we=1, dmem_wdata=32'h1234, stall high for 1 cycle, regwrite_out=0.
- Load with no ack, TIMEOUT=16 -> completes after 16 ACCESS cycles with read_data_out=32'hDEADBEEF; mem_error=1 and persists through the following ALU ops.
- Reset pulse mid-ACCESS, then an ack 2 cycles later -> outputs zero, dmem_req drops asynchronously, FSM in IDLE, late ack causes no MEM/WB update.
- Back-to-back load then ALU op, immediate ack -> ALU result appears in MEM/WB one cycle after the load data, with no lost or duplicated instruction.

Source files
------------

// File: rtl/mem_access_wb_pkg.sv
// Shared MEM-stage definitions: FSM encoding, MEM/WB field widths and timeout defaults.
package mem_access_wb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam int unsigned MEMWB_DATA_W = 32;
    localparam int unsigned MEMWB_REG_W  = 5;
    localparam int unsigned TIMEOUT_DEFAULT = 16;
    localparam logic [31:0] POISON_DEFAULT  = 32'hDEADBEEF;

    // Counter width able to hold 0..limit-1, never narrower than one bit
    function automatic int unsigned ctr_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/mem_access_wb_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the data memory (slave).
interface mem_access_wb_if
    import mem_access_wb_pkg::*;
#(
    parameter int unsigned DATA_W = MEMWB_DATA_W
);
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_timeout_ctr.sv
// Clear/enable saturating wait counter; expired is high while the count sits at TIMEOUT-1.
module mem_timeout_ctr
    import mem_access_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned     CNT_W = ctr_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             expired_d;

    // Expired is precomputed with the count so it is a clean register output
    always_comb begin
        count_d   = count_q;
        expired_d = expired;
        if (clr) begin
            count_d   = '0;
            expired_d = (LAST == '0);
        end else if (en && (count_q != LAST)) begin
            count_d   = count_q + CNT_W'(1);
            expired_d = (count_d == LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            expired <= 1'b0;
        end else begin
            count_q <= count_d;
            expired <= expired_d;
        end
    end

endmodule

// File: rtl/mem_access_wb.sv
// MEM stage: drives the variable-latency data memory over req/ack and produces the MEM/WB register.
module mem_access_wb
    import mem_access_wb_pkg::*;
#(
    parameter int unsigned       DATA_W  = MEMWB_DATA_W,
    parameter int unsigned       REG_W   = MEMWB_REG_W,
    parameter int unsigned       TIMEOUT = TIMEOUT_DEFAULT,
    parameter logic [DATA_W-1:0] POISON  = DATA_W'(POISON_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] read_data2,
    input  logic [REG_W-1:0]  regdst,
    input  logic              regwrite,
    input  logic              memwrite,
    input  logic              memread,
    input  logic              memtoreg,
    mem_access_wb_if.master   dmem,
    output logic              stall,
    output logic              mem_error,
    output logic [DATA_W-1:0] read_data_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [REG_W-1:0]  regdst_out,
    output logic              regwrite_out,
    output logic              memtoreg_out
);
    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [REG_W-1:0]  regdst_q, regdst_d;
    logic              rw_q, rw_d;
    logic              mtr_q, mtr_d;
    logic [REG_W-1:0]  cap_regdst_q, cap_regdst_d;
    logic              cap_rw_q, cap_rw_d;
    logic              cap_mtr_q, cap_mtr_d;
    logic              ctr_clr, ctr_en, ctr_expired;
    logic              ack;

    assign ack = dmem.dmem_ack;

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .expired (ctr_expired)
    );

    // Next-state and next-register logic; stall is the only combinational output
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        rd_d         = rd_q;
        alu_d        = alu_q;
        regdst_d     = regdst_q;
        rw_d         = rw_q;
        mtr_d        = mtr_q;
        cap_regdst_d = cap_regdst_q;
        cap_rw_d     = cap_rw_q;
        cap_mtr_d    = cap_mtr_q;
        stall        = 1'b0;
        ctr_clr      = 1'b0;
        ctr_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (memread || memwrite) begin
                    stall        = 1'b1;
                    ctr_clr      = 1'b1;
                    state_d      = ACCESS;
                    req_d        = 1'b1;
                    we_d         = memwrite;
                    addr_d       = alu_result;
                    wdata_d      = read_data2;
                    cap_regdst_d = regdst;
                    cap_rw_d     = regwrite;
                    cap_mtr_d    = memtoreg;
                    rw_d         = 1'b0;
                    mtr_d        = 1'b0;
                end else begin
                    rd_d     = '0;
                    alu_d    = alu_result;
                    regdst_d = regdst;
                    rw_d     = regwrite;
                    mtr_d    = memtoreg;
                end
            end
            ACCESS: begin
                // An ack in the expiry cycle wins over the timeout
                if (ack || ctr_expired) begin
                    rd_d     = ack ? (we_q ? '0 : dmem.dmem_rdata) : POISON;
                    err_d    = err_q | ~ack;
                    alu_d    = addr_q;
                    regdst_d = cap_regdst_q;
                    rw_d     = cap_rw_q;
                    mtr_d    = cap_mtr_q;
                    req_d    = 1'b0;
                    state_d  = IDLE;
                end else begin
                    stall  = 1'b1;
                    ctr_en = 1'b1;
                    rw_d   = 1'b0;
                    mtr_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            rd_q         <= '0;
            alu_q        <= '0;
            regdst_q     <= '0;
            rw_q         <= 1'b0;
            mtr_q        <= 1'b0;
            cap_regdst_q <= '0;
            cap_rw_q     <= 1'b0;
            cap_mtr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            rd_q         <= rd_d;
            alu_q        <= alu_d;
            regdst_q     <= regdst_d;
            rw_q         <= rw_d;
            mtr_q        <= mtr_d;
            cap_regdst_q <= cap_regdst_d;
            cap_rw_q     <= cap_rw_d;
            cap_mtr_q    <= cap_mtr_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign mem_error       = err_q;
    assign read_data_out   = rd_q;
    assign alu_result_out  = alu_q;
    assign regdst_out      = regdst_q;
    assign regwrite_out    = rw_q;
    assign memtoreg_out    = mtr_q;

endmodule
